// File: rtl/axil_user_master.sv
// AXI-Lite master bridging a level-based user read/write request interface
// onto a single-outstanding AXI4-Lite transaction.
module axil_user_master #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    // user side
    input  logic                  write,
    input  logic                  read,
    input  logic [ADDR_W-1:0]     user_waddr,
    input  logic [DATA_W-1:0]     user_wdata,
    input  logic [ADDR_W-1:0]     user_raddr,
    output logic [DATA_W-1:0]     user_rdata,
    output logic                  wr_ready,
    output logic                  rd_ready,
    output logic                  wr_err,
    output logic                  rd_err,
    // AXI-Lite write address
    output logic [ADDR_W-1:0]     m_awaddr,
    output logic [2:0]            m_awprot,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    // AXI-Lite write data
    output logic [DATA_W-1:0]     m_wdata,
    output logic [DATA_W/8-1:0]   m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    // AXI-Lite write response
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    // AXI-Lite read address
    output logic [ADDR_W-1:0]     m_araddr,
    output logic [2:0]            m_arprot,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    // AXI-Lite read data
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready
);

    typedef enum logic [2:0] {
        IDLE,
        WR_ADDR_DATA,
        WR_RESP,
        RD_ADDR,
        RD_DATA,
        DONE
    } state_t;

    state_t              state_q, state_d;
    logic                awvalid_q, awvalid_d;
    logic                wvalid_q, wvalid_d;
    logic                arvalid_q, arvalid_d;
    logic [ADDR_W-1:0]   awaddr_q, awaddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic                wr_ready_q, wr_ready_d;
    logic                rd_ready_q, rd_ready_d;
    logic                wr_err_q, wr_err_d;
    logic                rd_err_q, rd_err_d;
    // 1 when the most recent grant was a write; reset to 0 so write wins first
    logic                last_wr_q, last_wr_d;
    logic                grant_wr, grant_rd;

    // State and datapath registers, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q    <= IDLE;
            awvalid_q  <= 1'b0;
            wvalid_q   <= 1'b0;
            arvalid_q  <= 1'b0;
            awaddr_q   <= '0;
            wdata_q    <= '0;
            araddr_q   <= '0;
            rdata_q    <= '0;
            wr_ready_q <= 1'b0;
            rd_ready_q <= 1'b0;
            wr_err_q   <= 1'b0;
            rd_err_q   <= 1'b0;
            last_wr_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            awvalid_q  <= awvalid_d;
            wvalid_q   <= wvalid_d;
            arvalid_q  <= arvalid_d;
            awaddr_q   <= awaddr_d;
            wdata_q    <= wdata_d;
            araddr_q   <= araddr_d;
            rdata_q    <= rdata_d;
            wr_ready_q <= wr_ready_d;
            rd_ready_q <= rd_ready_d;
            wr_err_q   <= wr_err_d;
            rd_err_q   <= rd_err_d;
            last_wr_q  <= last_wr_d;
        end
    end

    // Next-state logic: arbitration, handshake tracking and response capture
    always_comb begin
        state_d    = state_q;
        awvalid_d  = awvalid_q;
        wvalid_d   = wvalid_q;
        arvalid_d  = arvalid_q;
        awaddr_d   = awaddr_q;
        wdata_d    = wdata_q;
        araddr_d   = araddr_q;
        rdata_d    = rdata_q;
        wr_ready_d = 1'b0;
        rd_ready_d = 1'b0;
        wr_err_d   = wr_err_q;
        rd_err_d   = rd_err_q;
        last_wr_d  = last_wr_q;
        grant_wr   = 1'b0;
        grant_rd   = 1'b0;

        case (state_q)
            IDLE: begin
                grant_wr = write && (!read || !last_wr_q);
                grant_rd = read && !grant_wr;
                if (grant_wr) begin
                    state_d   = WR_ADDR_DATA;
                    awvalid_d = 1'b1;
                    wvalid_d  = 1'b1;
                    awaddr_d  = user_waddr;
                    wdata_d   = user_wdata;
                    last_wr_d = 1'b1;
                end else if (grant_rd) begin
                    state_d   = RD_ADDR;
                    arvalid_d = 1'b1;
                    araddr_d  = user_raddr;
                    last_wr_d = 1'b0;
                end
            end
            WR_ADDR_DATA: begin
                // each VALID clears on its own handshake; leave once both are gone
                if (awvalid_q && m_awready) awvalid_d = 1'b0;
                if (wvalid_q && m_wready)   wvalid_d  = 1'b0;
                if (!awvalid_d && !wvalid_d) state_d = WR_RESP;
            end
            WR_RESP: begin
                if (m_bvalid) begin
                    state_d    = DONE;
                    wr_ready_d = 1'b1;
                    wr_err_d   = (m_bresp != 2'b00);
                end
            end
            RD_ADDR: begin
                if (m_arready) begin
                    arvalid_d = 1'b0;
                    state_d   = RD_DATA;
                end
            end
            RD_DATA: begin
                if (m_rvalid) begin
                    state_d    = DONE;
                    rdata_d    = m_rdata;
                    rd_err_d   = (m_rresp != 2'b00);
                    rd_ready_d = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign m_awaddr   = awaddr_q;
    assign m_awprot   = 3'b000;
    assign m_awvalid  = awvalid_q;
    assign m_wdata    = wdata_q;
    assign m_wstrb    = '1;
    assign m_wvalid   = wvalid_q;
    assign m_bready   = (state_q == WR_RESP);
    assign m_araddr   = araddr_q;
    assign m_arprot   = 3'b000;
    assign m_arvalid  = arvalid_q;
    assign m_rready   = (state_q == RD_DATA);
    assign user_rdata = rdata_q;
    assign wr_ready   = wr_ready_q;
    assign rd_ready   = rd_ready_q;
    assign wr_err     = wr_err_q;
    assign rd_err     = rd_err_q;

endmodule

// File: doc/axil_user_master.md
AXIL_USER_MASTER -- requirements
Module: axil_user_master

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, meaning width of user and AXI address.
REQ-002 SHALL have parameter DATA_W, default 32, meaning width of user and AXI data; WSTRB width is DATA_W/8.
REQ-003 SHALL have ports:
  clk  in  1  clock; all logic on rising edge
  resetn  in  1  reset, synchronous, active-low
  write  in  1  user write request, level, held until wr_ready
  read  in  1  user read request, level, held until rd_ready
  user_waddr  in  ADDR_W  write address
  user_wdata  in  DATA_W  write data
  user_raddr  in  ADDR_W  read address
  user_rdata  out  DATA_W  read data, valid while rd_ready=1 and held until next read completes
  wr_ready  out  1  one-cycle write-complete pulse
  rd_ready  out  1  one-cycle read-complete pulse
  wr_err  out  1  BRESP of last write != OKAY; updated with wr_ready
  rd_err  out  1  RRESP of last read != OKAY; updated with rd_ready
  m_awaddr/m_awprot/m_awvalid/m_awready  out/out/out/in  ADDR_W/3/1/1  AXI-Lite AW
  m_wdata/m_wstrb/m_wvalid/m_wready  out/out/out/in  DATA_W/DATA_W/8/1/1  AXI-Lite W
  m_bresp/m_bvalid/m_bready  in/in/out  2/1/1  AXI-Lite B
  m_araddr/m_arprot/m_arvalid/m_arready  out/out/out/in  ADDR_W/3/1/1  AXI-Lite AR
  m_rdata/m_rresp/m_rvalid/m_rready  in/in/in/out  DATA_W/2/1/1  AXI-Lite R

Function
REQ-004 SHALL implement FSM states IDLE, WR_ADDR_DATA, WR_RESP, RD_ADDR, RD_DATA, DONE; one transaction outstanding at a time.
REQ-005 In IDLE, write=1 and read=0 SHALL go to WR_ADDR_DATA; read=1 and write=0 SHALL go to RD_ADDR; neither SHALL stay IDLE.
REQ-006 If write and read are both 1 in IDLE, grant SHALL alternate: the type not granted last; after reset, write wins first.
REQ-007 On grant, address (and data for writes) SHALL be latched and held stable on m_* until the corresponding handshake.
REQ-008 m_awvalid and m_wvalid SHALL both rise the cycle after grant; each SHALL drop the cycle after its own VALID&READY, independent of the other.
REQ-009 WR_ADDR_DATA SHALL go to WR_RESP once both AW and W handshakes have occurred (same or different cycles); m_bready SHALL be 1 only in WR_RESP.
REQ-010 On m_bvalid&m_bready, FSM SHALL go to DONE; wr_ready=1 and wr_err=(m_bresp!=2'b00) SHALL appear the next cycle.
REQ-011 m_arvalid SHALL rise the cycle after read grant and drop after m_arready handshake; FSM then SHALL go to RD_DATA with m_rready=1 only in RD_DATA.
REQ-012 On m_rvalid&m_rready, user_rdata SHALL capture m_rdata, rd_err=(m_rresp!=2'b00), FSM to DONE; rd_ready=1 the next cycle.
REQ-013 DONE SHALL last exactly one cycle (the ready pulse cycle), then return to IDLE; requests are not sampled in DONE, preventing double-issue while the requester deasserts.
REQ-014 m_awprot and m_arprot SHALL be 3'b000; m_wstrb SHALL be all ones.
REQ-015 VALID signals SHALL never depend combinationally on READY inputs; no VALID SHALL drop before its handshake.
REQ-016 Slave response inputs arriving outside the matching state SHALL be ignored.
REQ-017 Minimum latency with always-ready slave and BVALID/RVALID one cycle after handshake: grant edge N, wr_ready/rd_ready at N+3.

Reset
REQ-018 resetn=0 at a rising edge SHALL force IDLE and set all VALID/READY outputs, wr_ready, rd_ready, wr_err, rd_err, user_rdata, latched address/data to 0, including mid-transaction; arbitration returns to write-first.

Verification
REQ-019 Write 0x0000_0000/0x0000_1234, slave always ready, BVALID next cycle OKAY -> AW/W valid together one cycle, wr_ready single pulse at grant+3, wr_err=0.
REQ-020 Write with m_awready delayed 3 cycles, m_wready immediate -> m_wvalid drops after 1 cycle, m_awvalid held 4 cycles with stable addr, m_bready only after both.
REQ-021 Read addr 0x0, slave returns RDATA 0x0000_ABCD RRESP=2'b10 -> user_rdata=0x0000_ABCD, rd_err=1, rd_ready one pulse.
REQ-022 write and read held 1 continuously -> grants alternate W,R,W,R; no transaction issued in DONE cycles; requester holding write high after wr_ready issues no extra transaction until IDLE.
REQ-023 resetn low while in WR_RESP -> next cycle all VALID/READY and pulses 0, FSM IDLE; after release a new write completes normally.
